// File: rtl/scan_code_event_queue.sv
// Folds PS/2 scan-code bytes (E0 / F0 prefixes) into key events and queues them in a show-ahead FIFO.
// Optional typematic-repeat suppression is enabled with SCAN_CODE_REPEAT_FILTER_EN.
module scan_code_event_queue #(
    parameter int FIFO_DEPTH  = 8,
    parameter int COUNT_WIDTH = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   fpga_clock,
    input  logic                   fpga_reset_n,
    input  logic [7:0]             scan_code_in,
    input  logic                   scan_code_valid,
    output logic [7:0]             key_code,
    output logic                   key_extended,
    output logic                   key_released,
    output logic                   key_event_valid,
    input  logic                   key_event_ready,
    output logic [COUNT_WIDTH-1:0] fifo_count,
    output logic                   overflow,
    input  logic                   clear_overflow,
    output logic                   protocol_error
);
    localparam int PTR_WIDTH = COUNT_WIDTH - 1;
    localparam logic [COUNT_WIDTH-1:0] DEPTH_C = COUNT_WIDTH'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_GOT_E0    = 2'd1,
        ST_GOT_F0    = 2'd2,
        ST_GOT_E0_F0 = 2'd3
    } state_t;

    // 0x00 / 0xFF are keyboard error and overrun indications, never part of an event
    function automatic logic is_error_code(input logic [7:0] code);
        return (code == 8'h00) || (code == 8'hFF);
    endfunction

    state_t                 state_r, next_state_s;
    logic                   evt_done_s, evt_ext_s, evt_rel_s, err_s;
    logic                   push_req_s, push_s, pop_s, drop_s, fifo_full_s, fifo_empty_s;
    logic [9:0]             mem_r [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]   wr_ptr_r, rd_ptr_r;
    logic [COUNT_WIDTH-1:0] count_r;
    logic                   overflow_r, protocol_error_r;
    logic [9:0]             head_s;

    // Prefix decoder: next state, completed-event flags and protocol error
    always_comb begin
        next_state_s = state_r;
        evt_done_s   = 1'b0;
        evt_ext_s    = 1'b0;
        evt_rel_s    = 1'b0;
        err_s        = 1'b0;
        if (scan_code_valid) begin
            if (is_error_code(scan_code_in)) begin
                err_s        = 1'b1;
                next_state_s = ST_IDLE;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (scan_code_in == 8'hE0) begin
                            next_state_s = ST_GOT_E0;
                        end else if (scan_code_in == 8'hF0) begin
                            next_state_s = ST_GOT_F0;
                        end else begin
                            evt_done_s   = 1'b1;
                            next_state_s = ST_IDLE;
                        end
                    end
                    ST_GOT_E0: begin
                        if (scan_code_in == 8'hF0) begin
                            next_state_s = ST_GOT_E0_F0;
                        end else if (scan_code_in == 8'hE0) begin
                            err_s        = 1'b1;
                            next_state_s = ST_GOT_E0;
                        end else begin
                            evt_done_s   = 1'b1;
                            evt_ext_s    = 1'b1;
                            next_state_s = ST_IDLE;
                        end
                    end
                    ST_GOT_F0, ST_GOT_E0_F0: begin
                        next_state_s = ST_IDLE;
                        if ((scan_code_in == 8'hE0) || (scan_code_in == 8'hF0)) begin
                            err_s = 1'b1;
                        end else begin
                            evt_done_s = 1'b1;
                            evt_ext_s  = (state_r == ST_GOT_E0_F0);
                            evt_rel_s  = 1'b1;
                        end
                    end
                    default: begin
                        next_state_s = ST_IDLE;
                    end
                endcase
            end
        end else begin
            next_state_s = state_r;
        end
    end

    // Prefix state register
    always_ff @(posedge fpga_clock or negedge fpga_reset_n) begin
        if (!fpga_reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

`ifdef SCAN_CODE_REPEAT_FILTER_EN
    logic [511:0] key_held_r;
    logic [8:0]   key_idx_s;

    // A make for a key already held is a typematic repeat and is not queued
    always_comb begin
        key_idx_s  = {evt_ext_s, scan_code_in};
        push_req_s = evt_done_s && !(!evt_rel_s && key_held_r[key_idx_s]);
    end

    // Held-key table: make sets, break clears
    always_ff @(posedge fpga_clock or negedge fpga_reset_n) begin
        if (!fpga_reset_n) begin
            key_held_r <= '0;
        end else if (evt_done_s) begin
            key_held_r[key_idx_s] <= ~evt_rel_s;
        end else begin
            key_held_r <= key_held_r;
        end
    end
`else
    // Every completed event is offered to the FIFO
    always_comb begin
        key_idx_unused_guard: push_req_s = evt_done_s;
    end
`endif

    // FIFO control; a pop frees the slot so push into a full FIFO succeeds alongside it
    always_comb begin
        fifo_empty_s = (count_r == {COUNT_WIDTH{1'b0}});
        fifo_full_s  = (count_r == DEPTH_C);
        pop_s        = !fifo_empty_s && key_event_ready;
        push_s       = push_req_s && (!fifo_full_s || pop_s);
        drop_s       = push_req_s && fifo_full_s && !pop_s;
        head_s       = mem_r[rd_ptr_r];
    end

    // Event storage
    always_ff @(posedge fpga_clock) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {evt_ext_s, evt_rel_s, scan_code_in};
        end
    end

    // Pointers, occupancy, sticky overflow and error pulse
    always_ff @(posedge fpga_clock or negedge fpga_reset_n) begin
        if (!fpga_reset_n) begin
            wr_ptr_r         <= {PTR_WIDTH{1'b0}};
            rd_ptr_r         <= {PTR_WIDTH{1'b0}};
            count_r          <= {COUNT_WIDTH{1'b0}};
            overflow_r       <= 1'b0;
            protocol_error_r <= 1'b0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + {{(PTR_WIDTH-1){1'b0}}, 1'b1};
            if (pop_s)  rd_ptr_r <= rd_ptr_r + {{(PTR_WIDTH-1){1'b0}}, 1'b1};
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (clear_overflow) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
            protocol_error_r <= err_s;
        end
    end

    assign key_event_valid = !fifo_empty_s;
    assign key_code        = fifo_empty_s ? 8'h00 : head_s[7:0];
    assign key_extended    = fifo_empty_s ? 1'b0 : head_s[9];
    assign key_released    = fifo_empty_s ? 1'b0 : head_s[8];
    assign fifo_count      = count_r;
    assign overflow        = overflow_r;
    assign protocol_error  = protocol_error_r;

endmodule
